rot_dma_ctrl: RTL and testbench

// - Sequencer directly upstream of the dma block. Drives its START/ADDR/COUNT/WRITE/SIZE command inputs.
// - Moves one image frame in tiles: AHB read burst into the input buffer -> rotate-core pass -> AHB write burst from the output buffer.
// - Advances source/destination addresses per tile; reports frame done/abort/error.

---
 rtl/rot_dma_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_rot_dma_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_dma_ctrl.sv
// rot_dma_ctrl -- tile sequencer in front of the AHB dma engine.
// Moves one frame as a series of tiles: read burst into the input buffer,
// rotate-core pass, write burst out of the output buffer. It then advances
// the source/destination pointers and reports frame done, abort or error.
//
// Ports
//   I_CTL_HCLK, I_CTL_HRESET        clock, async active-high reset
//   I_CTL_START, I_CTL_ABORT        frame start pulse, abort request
//   I_CTL_SRC_ADDR, I_CTL_DST_ADDR  frame base byte addresses (word aligned)
//   I_CTL_TOTAL_WORDS               frame length in 32-bit words
//   I_CTL_DMA_DONE, I_CTL_CORE_DONE completion pulses from dma / rotate core
//   O_CTL_DMA_*                     dma command (start, addr, count, write, size)
//   O_CTL_CORE_START                rotate-core start pulse
//   O_CTL_BUSY, O_CTL_DONE          frame in progress, frame-end pulse
//   O_CTL_ABORTED, O_CTL_ERR        sticky end-status flags
//
// Build option: define ROT_DMA_CTRL_TIMEOUT_EN to add a watchdog on the
// three wait states (TIMEOUT_CYC cycles). Without it ERR stays 0.
//
// state    | meaning
// IDLE     | no frame; waiting for START
// RD_REQ   | issue read burst of the current tile
// RD_WAIT  | read burst in flight
// ROT_REQ  | issue rotate-core start
// ROT_WAIT | rotate core busy
// WR_REQ   | issue write burst of the current tile
// WR_WAIT  | write burst in flight
// NEXT     | advance pointers, size the next tile or finish
module rot_dma_ctrl #(
   parameter int BURST_LEN   = 16,
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             I_CTL_HCLK,
   input  logic             I_CTL_HRESET,
   input  logic             I_CTL_START,
   input  logic             I_CTL_ABORT,
   input  logic [31:0]      I_CTL_SRC_ADDR,
   input  logic [31:0]      I_CTL_DST_ADDR,
   input  logic [LEN_W-1:0] I_CTL_TOTAL_WORDS,
   input  logic             I_CTL_DMA_DONE,
   input  logic             I_CTL_CORE_DONE,
   output logic             O_CTL_DMA_START,
   output logic [31:0]      O_CTL_DMA_ADDR,
   output logic [4:0]       O_CTL_DMA_COUNT,
   output logic             O_CTL_DMA_WRITE,
   output logic [2:0]       O_CTL_DMA_SIZE,
   output logic             O_CTL_CORE_START,
   output logic             O_CTL_BUSY,
   output logic             O_CTL_DONE,
   output logic             O_CTL_ABORTED,
   output logic             O_CTL_ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_ROT_REQ, S_ROT_WAIT, S_WR_REQ, S_WR_WAIT, S_NEXT
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      src_ptr, dst_ptr, beat_bytes;
   logic [LEN_W-1:0] remain, remain_adv;
   logic [4:0]       beats, beats_adv;
   logic             abort_q, done_q, aborted_q, err_q;
   logic             load_frame, advance, end_ok, end_abort, end_err;
   logic             abort_hit, in_wait, wd_tc, rd_phase, wr_phase;

   // beats is cleared on START, so the first pass through NEXT only sizes
   // the first tile; later passes retire the finished tile and size the next.
   assign beat_bytes = {25'd0, beats, 2'b00};
   assign remain_adv = remain - LEN_W'(beats);
   assign beats_adv  = (remain_adv > LEN_W'(BURST_LEN)) ? 5'(BURST_LEN) : remain_adv[4:0];
   assign in_wait    = (state == S_RD_WAIT) || (state == S_ROT_WAIT) || (state == S_WR_WAIT);
   assign abort_hit  = abort_q | I_CTL_ABORT;

`ifdef ROT_DMA_CTRL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wait_entry;

   assign wait_entry = (state_nxt != state) &&
                       ((state_nxt == S_RD_WAIT) || (state_nxt == S_ROT_WAIT) ||
                        (state_nxt == S_WR_WAIT));

   // Loaded on entry so terminal count lands exactly TIMEOUT_CYC cycles later.
   always_ff @(posedge I_CTL_HCLK or posedge I_CTL_HRESET) begin
      if (I_CTL_HRESET) begin
         wd_cnt <= '0;
      end else if (wait_entry) begin
         wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
      end else if (in_wait && (wd_cnt != '0)) begin
         wd_cnt <= wd_cnt - 1'b1;
      end
   end

   assign wd_tc = in_wait && (wd_cnt == '0);
`else
   // Watchdog compiled out: constant false for any legal TIMEOUT_CYC.
   assign wd_tc = (TIMEOUT_CYC < 0);
`endif

   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      advance    = 1'b0;
      end_ok     = 1'b0;
      end_abort  = 1'b0;
      end_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (I_CTL_START) begin
               load_frame = 1'b1;
               state_nxt  = S_NEXT;
            end
         end
         S_RD_REQ:  state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (I_CTL_DMA_DONE) begin
               end_abort = abort_hit;
               state_nxt = abort_hit ? S_IDLE : S_ROT_REQ;
            end else if (wd_tc) begin
               end_err   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_ROT_REQ:  state_nxt = S_ROT_WAIT;
         S_ROT_WAIT: begin
            if (I_CTL_CORE_DONE) begin
               end_abort = abort_hit;
               state_nxt = abort_hit ? S_IDLE : S_WR_REQ;
            end else if (wd_tc) begin
               end_err   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_WR_REQ:  state_nxt = S_WR_WAIT;
         S_WR_WAIT: begin
            if (I_CTL_DMA_DONE) begin
               end_abort = abort_hit;
               state_nxt = abort_hit ? S_IDLE : S_NEXT;
            end else if (wd_tc) begin
               end_err   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_NEXT: begin
            advance = 1'b1;
            if (remain_adv == '0) begin
               end_ok    = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_RD_REQ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge I_CTL_HCLK or posedge I_CTL_HRESET) begin
      if (I_CTL_HRESET) begin
         state     <= S_IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remain    <= '0;
         beats     <= '0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= end_ok | end_abort | end_err;
         if (load_frame) begin
            src_ptr   <= I_CTL_SRC_ADDR;
            dst_ptr   <= I_CTL_DST_ADDR;
            remain    <= I_CTL_TOTAL_WORDS;
            beats     <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
         end else begin
            if (advance) begin
               src_ptr <= src_ptr + beat_bytes;
               dst_ptr <= dst_ptr + beat_bytes;
               remain  <= remain_adv;
               beats   <= beats_adv;
            end
            if (state_nxt == S_IDLE) begin
               abort_q <= 1'b0;
            end else if (I_CTL_ABORT && (state != S_IDLE)) begin
               abort_q <= 1'b1;
            end
            if (end_abort) aborted_q <= 1'b1;
            if (end_err)   err_q     <= 1'b1;
         end
      end
   end

   assign rd_phase = (state == S_RD_REQ) || (state == S_RD_WAIT);
   assign wr_phase = (state == S_WR_REQ) || (state == S_WR_WAIT);

   assign O_CTL_DMA_START  = (state == S_RD_REQ) || (state == S_WR_REQ);
   assign O_CTL_DMA_ADDR   = wr_phase ? dst_ptr : (rd_phase ? src_ptr : 32'd0);
   assign O_CTL_DMA_COUNT  = (rd_phase || wr_phase) ? beats : 5'd0;
   assign O_CTL_DMA_WRITE  = wr_phase;
   assign O_CTL_DMA_SIZE   = 3'b010;
   assign O_CTL_CORE_START = (state == S_ROT_REQ);
   assign O_CTL_BUSY       = (state != S_IDLE);
   assign O_CTL_DONE       = done_q;
   assign O_CTL_ABORTED    = aborted_q;
   assign O_CTL_ERR        = err_q;

endmodule

// File: tb/tb_rot_dma_ctrl.sv
// Bench for rot_dma_ctrl: directed frame scenarios plus randomized frames
// checked against a tile-list model of the frame transfer.
module tb_rot_dma_ctrl;
   localparam int LEN_W       = 16;
   localparam int TIMEOUT_CYC = 1024;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0, abort = 1'b0;
   logic [31:0]      src_addr = '0, dst_addr = '0;
   logic [LEN_W-1:0] total_words = '0;
   logic             dma_done, core_done;
   logic             dma_start, dma_write, core_start, busy, done, aborted, err;
   logic [31:0]      dma_addr;
   logic [4:0]       dma_count;
   logic [2:0]       dma_size;

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  count;
      logic        write;
      int          cyc;
   } req_t;

   req_t req_log[$];
   int   core_log[$], done_log[$], dmadone_log[$], coredone_log[$];
   int   cyc = 0;
   int   vectors = 0, miscompares = 0;
   int   dma_fixed = 0, core_fixed = 0;
   bit   core_hold = 1'b0;
   int   start_cyc = 0;

   rot_dma_ctrl #(.BURST_LEN(16), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .I_CTL_HCLK(clk), .I_CTL_HRESET(rst), .I_CTL_START(start), .I_CTL_ABORT(abort),
      .I_CTL_SRC_ADDR(src_addr), .I_CTL_DST_ADDR(dst_addr), .I_CTL_TOTAL_WORDS(total_words),
      .I_CTL_DMA_DONE(dma_done), .I_CTL_CORE_DONE(core_done),
      .O_CTL_DMA_START(dma_start), .O_CTL_DMA_ADDR(dma_addr), .O_CTL_DMA_COUNT(dma_count),
      .O_CTL_DMA_WRITE(dma_write), .O_CTL_DMA_SIZE(dma_size), .O_CTL_CORE_START(core_start),
      .O_CTL_BUSY(busy), .O_CTL_DONE(done), .O_CTL_ABORTED(aborted), .O_CTL_ERR(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dma_done)  dmadone_log.push_back(cyc);
      if (core_done) coredone_log.push_back(cyc);
   end

   always @(negedge clk) begin
      req_t r;
      if (dma_start) begin
         r.addr = dma_addr; r.count = dma_count; r.write = dma_write; r.cyc = cyc;
         req_log.push_back(r);
      end
      if (core_start) core_log.push_back(cyc);
      if (done)       done_log.push_back(cyc);
   end

   // dma / core responder: answers each request after a fixed or random delay
   initial begin
      bit dma_pend, core_pend;
      int dma_cnt, core_cnt;
      dma_pend = 0; core_pend = 0; dma_cnt = 0; core_cnt = 0;
      dma_done = 1'b0; core_done = 1'b0;
      forever begin
         @(negedge clk);
         dma_done  = 1'b0;
         core_done = 1'b0;
         if (dma_pend) begin
            if (dma_cnt == 0) begin dma_done = 1'b1; dma_pend = 0; end
            else dma_cnt--;
         end
         if (core_pend) begin
            if (core_cnt == 0) begin core_done = 1'b1; core_pend = 0; end
            else core_cnt--;
         end
         if (dma_start) begin
            dma_pend = 1;
            dma_cnt  = (dma_fixed >= 0) ? dma_fixed : int'($urandom_range(0, 4));
         end
         if (core_start && !core_hold) begin
            core_pend = 1;
            core_cnt  = (core_fixed >= 0) ? core_fixed : int'($urandom_range(0, 4));
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 80000 cycles");
      $fatal(1, "global timeout");
   end

   task automatic clear_logs();
      req_log.delete(); core_log.delete(); done_log.delete();
      dmadone_log.delete(); coredone_log.delete();
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] t);
      @(negedge clk);
      src_addr = s; dst_addr = d; total_words = t; start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (done_log.size() > 0) begin ok = 1; break; end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_frame(input logic [31:0] s, input logic [31:0] d,
                            input logic [LEN_W-1:0] t, output bit ok);
      clear_logs();
      pulse_start(s, d, t);
      wait_done(5000, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (dma_start !== 1'b0) begin miscompares++; $display("FAIL reset_dma_start: got %b want 0", dma_start); end
      vectors++; if (dma_addr !== 32'd0) begin miscompares++; $display("FAIL reset_dma_addr: got %h want 0", dma_addr); end
      vectors++; if (dma_count !== 5'd0) begin miscompares++; $display("FAIL reset_dma_count: got %0d want 0", dma_count); end
      vectors++; if (dma_write !== 1'b0) begin miscompares++; $display("FAIL reset_dma_write: got %b want 0", dma_write); end
      vectors++; if (dma_size !== 3'b010) begin miscompares++; $display("FAIL reset_dma_size: got %b want 010", dma_size); end
      vectors++; if ({core_start, busy, done, aborted, err} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b want 00000", {core_start, busy, done, aborted, err});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_frame_40();
      bit ok;
      logic [31:0] ea [6];
      int ec [6];
      ea = '{32'h1000, 32'h8000, 32'h1040, 32'h8040, 32'h1080, 32'h8080};
      ec = '{16, 16, 16, 16, 8, 8};
      dma_fixed = 0; core_fixed = 0;
      run_frame(32'h1000, 32'h8000, 16'd40, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL f40_done_timeout: no DONE, want DONE"); end
      vectors++; if (req_log.size() != 6) begin miscompares++; $display("FAIL f40_burst_count: got %0d want 6", req_log.size()); end
      for (int i = 0; i < 6 && i < req_log.size(); i++) begin
         vectors++;
         if (req_log[i].addr !== ea[i] || req_log[i].count !== 5'(ec[i]) || req_log[i].write !== 1'(i % 2)) begin
            miscompares++;
            $display("FAIL f40_burst%0d: got addr %h cnt %0d wr %b want addr %h cnt %0d wr %0d",
                     i, req_log[i].addr, req_log[i].count, req_log[i].write, ea[i], ec[i], i % 2);
         end
      end
      vectors++; if (core_log.size() != 3) begin miscompares++; $display("FAIL f40_core_starts: got %0d want 3", core_log.size()); end
      vectors++; if (done_log.size() != 1) begin miscompares++; $display("FAIL f40_done_pulses: got %0d want 1", done_log.size()); end
      vectors++; if (aborted !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL f40_status: got ab %b err %b want 0 0", aborted, err); end
      if (req_log.size() >= 2 && core_log.size() >= 1 && dmadone_log.size() >= 1 && coredone_log.size() >= 1) begin
         vectors++; if (req_log[0].cyc - start_cyc != 2) begin miscompares++; $display("FAIL lat_start_to_req: got %0d want 2", req_log[0].cyc - start_cyc); end
         vectors++; if (core_log[0] - dmadone_log[0] != 1) begin miscompares++; $display("FAIL lat_rd_done_to_core: got %0d want 1", core_log[0] - dmadone_log[0]); end
         vectors++; if (req_log[1].cyc - coredone_log[0] != 1) begin miscompares++; $display("FAIL lat_core_done_to_wr: got %0d want 1", req_log[1].cyc - coredone_log[0]); end
      end else begin
         vectors++; miscompares++; $display("FAIL f40_latency_logs: got too few events want at least 2 bursts");
      end
   endtask

   task automatic test_zero_total();
      bit ok;
      int busy_cycles;
      clear_logs();
      busy_cycles = 0;
      pulse_start(32'h2000, 32'h3000, 16'd0);
      for (int i = 0; i < 10; i++) begin
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      wait_done(10, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL zero_done_missing: no DONE, want DONE"); end
      vectors++; if (req_log.size() != 0 || core_log.size() != 0) begin
         miscompares++; $display("FAIL zero_requests: got %0d dma %0d core want 0 0", req_log.size(), core_log.size());
      end
      vectors++; if (done_log.size() != 1 || (done_log.size() > 0 && done_log[0] - start_cyc != 2)) begin
         miscompares++; $display("FAIL zero_done_latency: got %0d pulses, want 1 pulse 2 cycles after START", done_log.size());
      end
      vectors++; if (busy_cycles != 1) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cycles); end
   endtask

   task automatic test_abort();
      bit ok, seen;
      int nrd, nwr;
      dma_fixed = 8; core_fixed = 0;
      clear_logs();
      pulse_start(32'h1000, 32'h8000, 16'd40);
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (req_log.size() >= 3) begin seen = 1; break; end
         @(negedge clk);
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL abort_tile2_read: got %0d bursts want 3 before abort", req_log.size()); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(200, ok);
      repeat (20) @(negedge clk);
      nrd = 0; nwr = 0;
      foreach (req_log[i]) if (req_log[i].write) nwr++; else nrd++;
      vectors++; if (!ok) begin miscompares++; $display("FAIL abort_done_missing: no DONE, want DONE"); end
      vectors++; if (nrd != 2 || nwr != 1) begin miscompares++; $display("FAIL abort_bursts: got rd %0d wr %0d want rd 2 wr 1", nrd, nwr); end
      vectors++; if (core_log.size() != 1) begin miscompares++; $display("FAIL abort_core_starts: got %0d want 1", core_log.size()); end
      vectors++; if (aborted !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got ab %b busy %b want 1 0", aborted, busy); end
      vectors++; if (done_log.size() != 1 || dmadone_log.size() != 3 || (done_log.size() > 0 && dmadone_log.size() > 2 && done_log[0] != dmadone_log[2] + 1)) begin
         miscompares++; $display("FAIL abort_done_timing: got %0d done %0d dma_done, want DONE 1 cycle after 3rd DMA_DONE", done_log.size(), dmadone_log.size());
      end
      dma_fixed = 0;
      run_frame(32'h100, 32'h200, 16'd4, ok);
      vectors++; if (!ok || aborted !== 1'b0) begin miscompares++; $display("FAIL abort_clear_on_start: got ok %b ab %b want 1 0", ok, aborted); end
   endtask

   task automatic test_start_while_busy();
      bit ok;
      dma_fixed = 3; core_fixed = 2;
      clear_logs();
      pulse_start(32'h2000, 32'h3000, 16'd16);
      repeat (2) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_during_frame: got %b want 1", busy); end
      pulse_start(32'h5000, 32'h6000, 16'd64);
      wait_done(200, ok);
      repeat (10) @(negedge clk);
      vectors++; if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL busy_restart_end: got ok %b busy %b want 1 0", ok, busy); end
      vectors++; if (req_log.size() != 2) begin miscompares++; $display("FAIL busy_restart_bursts: got %0d want 2", req_log.size()); end
      if (req_log.size() >= 2) begin
         vectors++;
         if (req_log[0].addr !== 32'h2000 || req_log[0].write !== 1'b0 || req_log[1].addr !== 32'h3000 ||
             req_log[1].write !== 1'b1 || req_log[1].count !== 5'd16) begin
            miscompares++;
            $display("FAIL busy_restart_addrs: got %h/%b %h/%b want 2000/0 3000/1",
                     req_log[0].addr, req_log[0].write, req_log[1].addr, req_log[1].write);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      dma_fixed = 1; core_fixed = 1;
      run_frame(32'hFFFF_FFC0, 32'h0000_0400, 16'd32, ok);
      vectors++; if (!ok || req_log.size() != 4) begin miscompares++; $display("FAIL wrap_bursts: got ok %b n %0d want 1 4", ok, req_log.size()); end
      if (req_log.size() >= 4) begin
         vectors++; if (req_log[0].addr !== 32'hFFFF_FFC0) begin miscompares++; $display("FAIL wrap_rd0_addr: got %h want ffffffc0", req_log[0].addr); end
         vectors++; if (req_log[2].addr !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_rd1_addr: got %h want 00000000", req_log[2].addr); end
         vectors++; if (req_log[3].addr !== 32'h0000_0440) begin miscompares++; $display("FAIL wrap_wr1_addr: got %h want 00000440", req_log[3].addr); end
      end
   endtask

   task automatic test_start_abort_same_cycle();
      bit ok;
      dma_fixed = 0; core_fixed = 0;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      clear_logs();
      @(negedge clk);
      src_addr = 32'h7000; dst_addr = 32'h9000; total_words = 16'd16; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      wait_done(200, ok);
      vectors++; if (!ok || aborted !== 1'b0) begin miscompares++; $display("FAIL start_abort_same: got ok %b ab %b want 1 0", ok, aborted); end
      vectors++; if (req_log.size() != 2 || core_log.size() != 1) begin
         miscompares++; $display("FAIL start_abort_reqs: got %0d dma %0d core want 2 1", req_log.size(), core_log.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      dma_fixed = 5; core_fixed = 0;
      clear_logs();
      pulse_start(32'h1000, 32'h8000, 16'd40);
      for (int i = 0; i < 20 && req_log.size() == 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || dma_addr !== 32'd0 || dma_count !== 5'd0) begin
         miscompares++; $display("FAIL midreset_outputs: got busy %b addr %h cnt %0d want 0 0 0", busy, dma_addr, dma_count);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_logs();
      repeat (20) @(negedge clk);
      vectors++; if (req_log.size() != 0 || core_log.size() != 0 || done_log.size() != 0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL midreset_stray_done: got %0d dma %0d core %0d done busy %b want 0 0 0 0",
                                 req_log.size(), core_log.size(), done_log.size(), busy);
      end
   endtask

   task automatic test_random_frames();
      bit ok;
      req_t exp_q[$];
      req_t e;
      logic [31:0] s, d;
      logic [LEN_W-1:0] t;
      int rem, off, b, tiles;
      dma_fixed = -1; core_fixed = -1;
      for (int f = 0; f < 10; f++) begin
         s = $urandom() & 32'hFFFF_FFFC;
         d = $urandom() & 32'hFFFF_FFFC;
         t = ($urandom_range(0, 7) == 0) ? 16'd0 : LEN_W'($urandom_range(1, 100));
         exp_q.delete();
         rem = int'(t); off = 0; tiles = 0;
         while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            e.addr = s + 32'(off * 4); e.count = 5'(b); e.write = 1'b0; e.cyc = 0; exp_q.push_back(e);
            e.addr = d + 32'(off * 4); e.write = 1'b1; exp_q.push_back(e);
            off += b; rem -= b; tiles++;
         end
         run_frame(s, d, t, ok);
         vectors++; if (!ok || done_log.size() != 1) begin miscompares++; $display("FAIL rnd%0d_done: got ok %b n %0d want 1 1", f, ok, done_log.size()); end
         vectors++; if (req_log.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_nbursts: got %0d want %0d", f, req_log.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
            vectors++;
            if (req_log[i].addr !== exp_q[i].addr || req_log[i].count !== exp_q[i].count || req_log[i].write !== exp_q[i].write) begin
               miscompares++;
               $display("FAIL rnd%0d_burst%0d: got %h/%0d/%b want %h/%0d/%b", f, i, req_log[i].addr, req_log[i].count,
                        req_log[i].write, exp_q[i].addr, exp_q[i].count, exp_q[i].write);
            end
         end
         vectors++; if (core_log.size() != tiles || aborted !== 1'b0 || err !== 1'b0) begin
            miscompares++; $display("FAIL rnd%0d_core_status: got core %0d ab %b err %b want %0d 0 0", f, core_log.size(), aborted, err, tiles);
         end
      end
   endtask

`ifdef ROT_DMA_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      dma_fixed = 0; core_fixed = 0; core_hold = 1'b1;
      run_frame(32'h4000, 32'h5000, 16'd16, ok);
      core_hold = 1'b0;
      vectors++; if (!ok || err !== 1'b1) begin miscompares++; $display("FAIL tmo_err: got ok %b err %b want 1 1", ok, err); end
      vectors++; if (req_log.size() != 1) begin miscompares++; $display("FAIL tmo_no_write: got %0d bursts want 1", req_log.size()); end
      vectors++; if (done_log.size() != 1 || core_log.size() != 1 || (done_log.size() > 0 && core_log.size() > 0 && done_log[0] != core_log[0] + 1 + TIMEOUT_CYC)) begin
         miscompares++; $display("FAIL tmo_latency: got %0d done %0d core, want DONE %0d cycles after ROT_WAIT entry", done_log.size(), core_log.size(), TIMEOUT_CYC);
      end
      run_frame(32'h0, 32'h0, 16'd0, ok);
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_clear: got %b want 0", err); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_40();
      test_zero_total();
      test_abort();
      test_start_while_busy();
      test_wrap();
      test_start_abort_same_cycle();
      test_reset_mid_frame();
      test_random_frames();
`ifdef ROT_DMA_CTRL_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
